// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall encodings, FSM states
// and the architectural data width.
package pipe_ctrl_pkg;

  localparam int DATA_WIDTH = 32;

  // Stall vector bit order: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
  // A stage that stalls also freezes every stage in front of it.
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Highest (deepest) requesting stage wins.
  function automatic logic [5:0] stall_encode(input logic req_mem,
                                              input logic req_ex,
                                              input logic req_id,
                                              input logic req_if);
    logic [5:0] enc;
    enc = STALL_NONE;
    if (req_mem)     enc = STALL_MEM;
    else if (req_ex) enc = STALL_EX;
    else if (req_id) enc = STALL_ID;
    else if (req_if) enc = STALL_IF;
    return enc;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // Next count: increment when enabled unless already saturated.
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall merging, redirect capture/replay while
// the PC is frozen, IF/ID and full-pipe flush, and PC-stall cycle counting.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  stallreq_if,
  input  logic                  stallreq_id,
  input  logic                  stallreq_ex,
  input  logic                  stallreq_mem,
  input  logic                  branch_flag,
  input  logic [DATA_WIDTH-1:0] branch_target_address,
  input  logic                  exc_req,
  input  logic [DATA_WIDTH-1:0] exc_target,
  output logic [5:0]            stall,
  output logic                  pc_branch_flag,
  output logic [DATA_WIDTH-1:0] pc_branch_target,
  output logic                  flush_if,
  output logic                  flush_all,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                  pend_exc_q, pend_exc_d;
  logic                  accept;
  logic [DATA_WIDTH-1:0] redir_addr;

  // Stall merge; an exception not blocked by MEM releases the pipe so the
  // trap can be taken immediately.
  always_comb begin
    stall = stall_encode(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);
    if (exc_req && !stallreq_mem) stall = STALL_NONE;
  end

  // Redirect acceptance, pending capture and replay to the PC.
  always_comb begin
    state_d          = state_q;
    pend_addr_d      = pend_addr_q;
    pend_exc_d       = pend_exc_q;
    accept           = 1'b0;
    redir_addr       = exc_req ? exc_target : branch_target_address;
    pc_branch_flag   = 1'b0;
    pc_branch_target = '0;
    flush_all        = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (exc_req || branch_flag) begin
          accept = 1'b1;
          if (!stall[0]) begin
            pc_branch_flag   = 1'b1;
            pc_branch_target = redir_addr;
            flush_all        = exc_req;
          end else begin
            state_d     = ST_PEND;
            pend_addr_d = redir_addr;
            pend_exc_d  = exc_req;
          end
        end
      end
      ST_PEND: begin
        // branch_flag is wrong-path here and deliberately ignored.
        if (!stall[0]) begin
          pc_branch_flag = 1'b1;
          state_d        = ST_RUN;
          pend_exc_d     = 1'b0;
          if (exc_req) begin
            pc_branch_target = exc_target;
            flush_all        = 1'b1;
          end else begin
            pc_branch_target = pend_addr_q;
            flush_all        = pend_exc_q;
          end
        end else if (exc_req) begin
          pend_addr_d = exc_target;
          pend_exc_d  = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Kill wrong-path fetches whenever IF/ID is free to load.
  always_comb begin
    flush_if = (accept || (state_q == ST_PEND) || pc_branch_flag) && !stall[1];
  end

  // FSM state and held redirect.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_RUN;
      pend_addr_q <= '0;
      pend_exc_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_exc_q  <= pend_exc_d;
    end
  end

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .en_i   (stall[0]),
    .count_o(stall_cycles)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl (32-bit and 4-bit counter builds).
module tb_pipe_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        branch_flag, exc_req;
  logic [31:0] branch_target_address, exc_target;

  logic [5:0]  stall, stall4;
  logic        pc_branch_flag, pc_branch_flag4;
  logic [31:0] pc_branch_target, pc_branch_target4;
  logic        flush_if, flush_if4, flush_all, flush_all4;
  logic [31:0] stall_cycles;
  logic [3:0]  stall_cycles4;

  always #5 CLK = ~CLK;

  pipe_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .branch_flag(branch_flag), .branch_target_address(branch_target_address),
    .exc_req(exc_req), .exc_target(exc_target),
    .stall(stall), .pc_branch_flag(pc_branch_flag),
    .pc_branch_target(pc_branch_target), .flush_if(flush_if),
    .flush_all(flush_all), .stall_cycles(stall_cycles)
  );

  pipe_ctrl #(.CNT_WIDTH(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .branch_flag(branch_flag), .branch_target_address(branch_target_address),
    .exc_req(exc_req), .exc_target(exc_target),
    .stall(stall4), .pc_branch_flag(pc_branch_flag4),
    .pc_branch_target(pc_branch_target4), .flush_if(flush_if4),
    .flush_all(flush_all4), .stall_cycles(stall_cycles4)
  );

  typedef struct {
    logic [5:0]  st;
    logic        pbf;
    logic [31:0] tgt;
    logic        fi;
    logic        fa;
    int          cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per cycle, sampled on the falling edge.
  exp_t e;
  int   c4;
  always @(negedge CLK) begin
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("stall", {26'd0, stall}, {26'd0, e.st});
      chk("pc_branch_flag", {31'd0, pc_branch_flag}, {31'd0, e.pbf});
      if (e.pbf) chk("pc_branch_target", pc_branch_target, e.tgt);
      chk("flush_if", {31'd0, flush_if}, {31'd0, e.fi});
      chk("flush_all", {31'd0, flush_all}, {31'd0, e.fa});
      if (e.cnt >= 0) begin
        chk("stall_cycles", stall_cycles, e.cnt);
        c4 = (e.cnt > 15) ? 15 : e.cnt;
        chk("stall_cycles_w4", {28'd0, stall_cycles4}, c4);
      end
    end
  end

  // req = {mem, ex, id, if}
  task automatic drive(input logic [3:0] req, input logic br, input logic [31:0] bta,
                       input logic exc, input logic [31:0] et,
                       input logic [5:0] st, input logic pbf, input logic [31:0] tgt,
                       input logic fi, input logic fa, input int cnt);
    exp_t x;
    stallreq_mem = req[3];
    stallreq_ex  = req[2];
    stallreq_id  = req[1];
    stallreq_if  = req[0];
    branch_flag  = br;
    branch_target_address = bta;
    exc_req      = exc;
    exc_target   = et;
    x.st = st; x.pbf = pbf; x.tgt = tgt; x.fi = fi; x.fa = fa; x.cnt = cnt;
    sbq.push_back(x);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0;
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    branch_flag = 0; exc_req = 0;
    branch_target_address = '0; exc_target = '0;
    @(posedge CLK);
    #1;
    // Reset state
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);
    RST_N = 1'b1;
    // Priority encode
    drive(4'b0101, 0, 0, 0, 0, 6'b001111, 0, 0, 0, 0, 0);
    drive(4'b1101, 0, 0, 0, 0, 6'b011111, 0, 0, 0, 0, 1);
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 2);
    drive(4'b0010, 0, 0, 0, 0, 6'b000111, 0, 0, 0, 0, 2);
    drive(4'b0001, 0, 0, 0, 0, 6'b000011, 0, 0, 0, 0, 3);
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 4);
    // Exception overrides EX stall, delivered directly
    drive(4'b0100, 0, 0, 1, 32'h80, 6'b000000, 1, 32'h80, 1, 1, 4);
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 4);
    // Direct branch
    drive(4'b0000, 1, 32'h100, 0, 0, 6'b000000, 1, 32'h100, 1, 0, 4);
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 4);
    // Exception beats simultaneous branch
    drive(4'b0000, 1, 32'h100, 1, 32'h44, 6'b000000, 1, 32'h44, 1, 1, 4);
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 4);
    // Held branch: 0x300 is wrong-path and must never appear
    drive(4'b0001, 1, 32'h200, 0, 0, 6'b000011, 0, 0, 0, 0, 4);
    drive(4'b0001, 1, 32'h300, 0, 0, 6'b000011, 0, 0, 0, 0, 5);
    drive(4'b0001, 0, 0, 0, 0, 6'b000011, 0, 0, 0, 0, 6);
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 1, 32'h200, 1, 0, 7);
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 7);
    // Exception overwrites pending branch under MEM stall
    drive(4'b1000, 1, 32'h200, 0, 0, 6'b011111, 0, 0, 0, 0, 7);
    drive(4'b1000, 0, 0, 1, 32'h80, 6'b011111, 0, 0, 0, 0, 8);
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 1, 32'h80, 1, 1, 9);
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 9);
    // Exception in PEND releasing the IF stall wins in the same cycle
    drive(4'b0001, 1, 32'h200, 0, 0, 6'b000011, 0, 0, 0, 0, 9);
    drive(4'b0001, 0, 0, 1, 32'h90, 6'b000000, 1, 32'h90, 1, 1, 10);
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 10);
    // Reset mid-PEND discards the held redirect
    drive(4'b0001, 1, 32'h200, 0, 0, 6'b000011, 0, 0, 0, 0, 10);
    RST_N = 1'b0;
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);
    RST_N = 1'b1;
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);
    // Saturation of the 4-bit build over 20 stalled cycles
    for (int i = 0; i < 20; i++) begin
      drive(4'b0001, 0, 0, 0, 0, 6'b000011, 0, 0, 0, 0, i);
    end
    drive(4'b0000, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 20);

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 5 && sbq.size() > 0; k++) @(posedge CLK);
    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the 5-stage RISC-V core. It merges per-stage stall requests into the `stall[5:0]` vector consumed by `pc_reg` and the pipeline registers. It captures branch and exception redirects that arrive while the PC is frozen and replays them to `pc_reg` on the first unfrozen cycle, so no redirect is lost. It also generates IF/ID flush and full-pipe flush, and counts PC-stall cycles.

## Interface
- `CNT_WIDTH`, 32, width of stall-cycle counter.
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: reset; one clock, asynchronous, active-low.
- `stallreq_if` in 1: instruction memory not ready.
- `stallreq_id` in 1: load-use hazard.
- `stallreq_ex` in 1: multi-cycle EX op busy.
- `stallreq_mem` in 1: data memory not ready.
- `branch_flag` in 1: taken branch/jump resolved in ID.
- `branch_target_address` in 32: target for `branch_flag`.
- `exc_req` in 1: trap/exception raised in MEM.
- `exc_target` in 32: trap vector for `exc_req`.
- `stall` out 6: bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
- `pc_branch_flag` out 1: redirect to `pc_reg`.
- `pc_branch_target` out 32: redirect address.
- `flush_if` out 1: IF/ID register loads NOP.
- `flush_all` out 1: IF/ID, ID/EX and EX/MEM load NOP.
- `stall_cycles` out CNT_WIDTH: saturating count of cycles with `stall[0]=1`.

## Operation
- Stall encoding is combinational, and the highest requesting stage wins:
  - mem: 011111
  - ex: 001111
  - id: 000111
  - if: 000011
  - none: 000000
- Exception handling forces the encoding to 000000 when `exc_req=1` and `stallreq_mem=0`.
- FSM states:
  - RUN: no redirect held.
  - PEND: redirect held in `pend_addr`, with `pend_exc` marking whether it is an exception.
- Accept rules in RUN:
  - `exc_req` takes priority over `branch_flag`.
  - If `stall[0]=0`, the accepted redirect drives `pc_branch_flag=1` and `pc_branch_target` combinationally in the same cycle. State stays RUN.
  - If `stall[0]=1`, the target is latched and the state moves to PEND.
- In PEND:
  - `branch_flag` is ignored, because it is wrong-path.
  - `exc_req` overwrites `pend_addr` and sets `pend_exc`.
  - On the first cycle with `stall[0]=0`, drive `pc_branch_flag=1` with `pend_addr`, then go to RUN.
  - If `exc_req` arrives in that same cycle, it wins and is delivered instead.
- `flush_if` = (accept | PEND | `pc_branch_flag`) & ~`stall[1]`. This kills wrong-path fetches.
- `flush_all` = 1 for exactly the cycle an exception is delivered to the PC, whether direct or from PEND.
- `stall_cycles` increments when `stall[0]=1` and holds at all-ones.
- Reset values: state RUN, `pend_addr=0`, `pend_exc=0`, `stall_cycles=0`.
  - Outputs then follow the combinational rules: with no requests, `stall=0`, `pc_branch_flag=0`, `flush_if=0`, `flush_all=0`.
- Reset mid-PEND discards the held redirect.

## Timing
- Stall requests to `stall`: 0 cycles (combinational).
- Direct redirect: 0-cycle path from `branch_flag`/`exc_req` to `pc_branch_flag`; `pc_reg` loads the target at the next edge.
- Pending redirect: delivered in the first cycle with `stall[0]=0`, from registered state.
  - Latency = stall duration, with no extra bubble.
- `pc_branch_flag` is never asserted while `stall[0]=1`.
- `pc_branch_flag` is asserted for exactly one cycle per redirect.
- Counter updates on the rising edge. Saturation: all-ones + stall = all-ones.

## Structure
- Shared package or `config.vh` holds:
  - the stall encodings (`STALL_MEM`, `STALL_EX`, `STALL_ID`, `STALL_IF`, `STALL_NONE`);
  - the FSM state constants;
  - `DATA_WIDTH`.
- One sub-module, `sat_counter` (`CNT_WIDTH`, enable, saturating), implements `stall_cycles`.
- Stall priority encode, FSM and pending register live in `pipe_ctrl`.

## Test plan
- Priority encode: `stallreq_if=1`, `stallreq_ex=1` → `stall=001111`; add `stallreq_mem` → 011111; release all → 000000.
- Direct branch: no stall, `branch_flag=1`, target 0x100 → same-cycle `pc_branch_flag=1`, target 0x100, `flush_if=1`; next cycle `pc_branch_flag=0`.
- Held branch: `stallreq_if=1` for 3 cycles, `branch_flag=1` (0x200) in cycle 0, `branch_flag=1` (0x300) in cycle 1 → single redirect to 0x200 in cycle 3; `flush_if=1` in cycles 0-3 when `stall[1]=0`; `stall_cycles=3`.
- Exception overrides pending: in PEND with 0x200, `exc_req=1` (0x80) while stalled → delivered 0x80, `flush_all=1` for one cycle, 0x200 never issued.
- Reset mid-PEND: deassert `RST_N` while holding 0x200 → outputs at reset values; after release, no redirect issued and `stall_cycles=0`.
- Saturation: `CNT_WIDTH=4`, 20 stalled cycles → `stall_cycles=15`.
